// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit for the execute stage: full-width multiplier
// plus an iterative radix-2 restoring divider, with EX stall and flush handling.
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            stall_req,
    output logic            busy,
    output logic            res_valid,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    localparam int CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    state_t            r_state;
    logic [CW-1:0]     r_count;
    logic              r_signed;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic              r_divZero;
    logic              r_negQ;
    logic              r_negR;
    logic [XLEN-1:0]   r_quot;
    logic [XLEN-1:0]   r_divisor;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    logic              w_reqSigned;
    logic [XLEN-1:0]   w_absA;
    logic [XLEN-1:0]   w_absB;
    logic [2*XLEN-1:0] w_aExt;
    logic [2*XLEN-1:0] w_bExt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_qBit;
    logic [XLEN-1:0]   w_nextRem;
    logic [XLEN-1:0]   w_fixQ;
    logic [XLEN-1:0]   w_fixR;

    // MULT and DIV (even opcodes) are the signed flavours.
    assign w_reqSigned = ~req_op[0];
    assign w_absA      = (w_reqSigned && src_a[XLEN-1]) ? -src_a : src_a;
    assign w_absB      = (w_reqSigned && src_b[XLEN-1]) ? -src_b : src_b;

    assign w_aExt = {{XLEN{r_signed & r_a[XLEN-1]}}, r_a};
    assign w_bExt = {{XLEN{r_signed & r_b[XLEN-1]}}, r_b};
    assign w_prod = w_aExt * w_bExt;

    // The trial value needs XLEN+1 bits; the kept remainder is always below the divisor.
    assign w_shift   = {r_rem, r_quot[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_divisor};
    assign w_qBit    = ~w_diff[XLEN];
    assign w_nextRem = w_qBit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

    assign w_fixQ = r_negQ ? -r_quot : r_quot;
    assign w_fixR = r_negR ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_signed  <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_divZero <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_signed  <= w_reqSigned;
                        r_a       <= src_a;
                        r_b       <= src_b;
                        r_divZero <= (src_b == '0);
                        r_negQ    <= w_reqSigned & (src_a[XLEN-1] ^ src_b[XLEN-1]);
                        r_negR    <= w_reqSigned & src_a[XLEN-1];
                        r_quot    <= w_absA;
                        r_divisor <= w_absB;
                        r_rem     <= '0;
                        if (req_op[1]) begin
                            r_state <= S_DIV;
                            r_count <= CW'(XLEN - 1);
                        end else begin
                            r_state <= S_MUL;
                            r_count <= CW'(MUL_STAGES - 1);
                        end
                    end
                end
                S_MUL: begin
                    if (r_count == '0) begin
                        {r_hi, r_lo} <= w_prod;
                        r_state      <= S_DONE;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                S_DIV: begin
                    r_rem  <= w_nextRem;
                    r_quot <= {r_quot[XLEN-2:0], w_qBit};
                    if (r_count == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                S_FIX: begin
                    // Divide by zero reports the raw dividend and skips the sign fixup.
                    if (r_divZero) begin
                        r_lo <= '1;
                        r_hi <= r_a;
                    end else begin
                        r_lo <= w_fixQ;
                        r_hi <= w_fixR;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_req = ((r_state == S_IDLE) & req_valid & ~flush)
                     | (r_state == S_MUL)
                     | (r_state == S_DIV)
                     | (r_state == S_FIX);
    assign busy      = (r_state != S_IDLE);
    assign res_valid = (r_state == S_DONE);
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases from the plan plus random
// operations compared against an arithmetic reference model.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        reqValid;
    logic [1:0]  reqOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        stallReq;
    logic        busy;
    logic        resValid;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stallReq4;
    logic        busy4;
    logic        resValid4;
    logic [31:0] hi4;
    logic [31:0] lo4;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] lastHi = '0;
    logic [31:0] lastLo = '0;

    ex_muldiv #(.XLEN(32), .MUL_STAGES(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (reqValid),
        .req_op    (reqOp),
        .src_a     (srcA),
        .src_b     (srcB),
        .stall_req (stallReq),
        .busy      (busy),
        .res_valid (resValid),
        .hi        (hi),
        .lo        (lo)
    );

    ex_muldiv #(.XLEN(32), .MUL_STAGES(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (reqValid),
        .req_op    (reqOp),
        .src_a     (srcA),
        .src_b     (srcB),
        .stall_req (stallReq4),
        .busy      (busy4),
        .res_valid (resValid4),
        .hi        (hi4),
        .lo        (lo4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: p = 64'(sa * sb);
            2'd1: p = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (op == 2'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request (valid for the accept cycle only) and follow it to completion.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        logic [63:0] exp;
        lat = op[1] ? 34 : 3;
        exp = model(op, a, b);
        step();
        reqValid = 1'b1;
        reqOp    = op;
        srcA     = a;
        srcB     = b;
        #1;
        checkOutput($sformatf("op%0d accept stall", op), 64'(stallReq), 64'd1);
        for (int c = 1; c <= lat + 1; c++) begin
            step();
            reqValid = 1'b0;
            #1;
            if (c <= lat) begin
                checkOutput($sformatf("op%0d c%0d stall", op, c), 64'(stallReq), 64'(c < lat));
                checkOutput($sformatf("op%0d c%0d res_valid", op, c), 64'(resValid), 64'(c == lat));
            end
            if (c == lat - 1)
                checkOutput($sformatf("op%0d hold hi/lo", op), {hi, lo}, {lastHi, lastLo});
            if (c == lat)
                checkOutput($sformatf("op%0d a=%h b=%h hi/lo", op, a, b), {hi, lo}, exp);
            if (c == lat + 1)
                checkOutput($sformatf("op%0d idle after done", op), {62'd0, busy, resValid}, 64'd0);
        end
        lastHi = exp[63:32];
        lastLo = exp[31:0];
    endtask

    initial begin
        int          pulses;
        logic [1:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        logic [63:0] exp;

        rst      = 1'b0;
        flush    = 1'b0;
        reqValid = 1'b0;
        reqOp    = 2'd0;
        srcA     = '0;
        srcB     = '0;
        step();
        step();
        checkOutput("reset outputs", {61'd0, stallReq, busy, resValid}, 64'd0);
        checkOutput("reset hi/lo", {hi, lo}, 64'd0);
        rst = 1'b1;

        // MULTU on both instances: result at cycle 3 (2 stages) and cycle 5 (4 stages).
        exp = model(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        reqValid = 1'b1;
        reqOp    = 2'd1;
        srcA     = 32'hFFFF_FFFF;
        srcB     = 32'hFFFF_FFFF;
        for (int c = 1; c <= 6; c++) begin
            step();
            reqValid = 1'b0;
            #1;
            checkOutput($sformatf("multu c%0d rv", c), 64'(resValid), 64'(c == 3));
            checkOutput($sformatf("multu4 c%0d rv", c), 64'(resValid4), 64'(c == 5));
            if (c == 3) checkOutput("multu hi/lo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
            if (c == 5) checkOutput("multu4 hi/lo", {hi4, lo4}, exp);
            if (c == 4) checkOutput("multu4 stall c4", 64'(stallReq4), 64'd1);
        end
        lastHi = exp[63:32];
        lastLo = exp[31:0];

        applyStimulus(2'd0, 32'hFFFF_FFFD, 32'd5);
        checkOutput("mult -3*5 const", {lastHi, lastLo}, 64'hFFFF_FFFF_FFFF_FFF1);
        applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div -7/2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(2'd3, 32'd100, 32'd7);
        checkOutput("divu 100/7 const", {hi, lo}, 64'h0000_0002_0000_000E);
        applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div minneg/-1 const", {hi, lo}, 64'h0000_0000_8000_0000);
        applyStimulus(2'd3, 32'h0000_1234, 32'd0);
        checkOutput("divu by zero const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        applyStimulus(2'd2, 32'hFFFF_FFFB, 32'd0);
        applyStimulus(2'd2, 32'd9, 32'h8000_0000);

        for (int i = 0; i < 24; i++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = $urandom;
            case ($urandom_range(0, 7))
                0:       rB = 32'd0;
                1:       rB = 32'($urandom_range(1, 15));
                2:       rB = 32'h8000_0000;
                3:       rB = 32'hFFFF_FFFF;
                default: rB = $urandom;
            endcase
            applyStimulus(rOp, rA, rB);
        end

        // Flush a divide at cycle 10, then a MULT 2x3 accepted at cycle 12.
        step();
        reqValid = 1'b1;
        reqOp    = 2'd2;
        srcA     = 32'hFFFF_FF9C;
        srcB     = 32'd7;
        for (int c = 1; c <= 15; c++) begin
            step();
            reqValid = 1'b0;
            flush    = (c == 10);
            if (c == 12) begin
                reqValid = 1'b1;
                reqOp    = 2'd0;
                srcA     = 32'd2;
                srcB     = 32'd3;
            end
            #1;
            checkOutput($sformatf("flush c%0d rv", c), 64'(resValid), 64'(c == 15));
            if (c == 11) begin
                checkOutput("flush idle", {62'd0, busy, stallReq}, 64'd0);
                checkOutput("flush hi/lo kept", {hi, lo}, {lastHi, lastLo});
            end
            if (c == 12) checkOutput("post-flush accept", 64'(stallReq), 64'd1);
            if (c == 15) checkOutput("post-flush mult", {hi, lo}, 64'd6);
        end
        lastHi = 32'd0;
        lastLo = 32'd6;

        // Flush landing on DONE leaves that cycle's result visible.
        step();
        reqValid = 1'b1;
        reqOp    = 2'd1;
        srcA     = 32'd7;
        srcB     = 32'd9;
        for (int c = 1; c <= 4; c++) begin
            step();
            reqValid = 1'b0;
            flush    = (c == 3);
            #1;
            if (c == 3) checkOutput("flush in done rv", {31'd0, resValid, lo}, {31'd0, 1'b1, 32'd63});
            if (c == 4) checkOutput("flush in done idle", 64'(busy), 64'd0);
        end
        flush  = 1'b0;
        lastLo = 32'd63;

        // Reset in the middle of a divide clears everything at once.
        step();
        reqValid = 1'b1;
        reqOp    = 2'd3;
        srcA     = 32'd1000;
        srcB     = 32'd3;
        for (int c = 1; c <= 20; c++) begin
            step();
            reqValid = 1'b0;
        end
        checkOutput("pre-reset busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("async reset ctl", {61'd0, stallReq, busy, resValid}, 64'd0);
        checkOutput("async reset hi/lo", {hi, lo}, 64'd0);
        step();
        rst = 1'b1;

        // Request held through DONE yields exactly one result pulse.
        rA  = $urandom;
        rB  = $urandom;
        exp = model(2'd0, rA, rB);
        pulses = 0;
        step();
        reqValid = 1'b1;
        reqOp    = 2'd0;
        srcA     = rA;
        srcB     = rB;
        for (int c = 1; c <= 10; c++) begin
            step();
            reqValid = (c <= 3);
            #1;
            if (resValid) pulses++;
            if (c == 3) checkOutput("held req result", {hi, lo}, exp);
            if (c == 4) checkOutput("held req no restart", 64'(busy), 64'd0);
        end
        checkOutput("held req pulse count", 64'(pulses), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle multiply/divide unit for the execute stage. It replaces the single-width ALU HI/LO path with a pipelined multiplier and an iterative radix-2 divider. It holds the EX stage through `stall_req` until its HI/LO pair is ready, then presents that pair to the EX stage for one cycle. A `flush` input allows an in-flight operation to be cancelled on exception or refetch.

## Interface
- `XLEN`, 32, operand and result width (≥ 8, even).
- `MUL_STAGES`, 2, multiplier busy cycles after accept (≥ 1).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  cancel any accepted or in-flight operation.
- `req_valid`  in  1  EX instruction requests a mul/div this cycle.
- `req_op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  XLEN  multiplicand / dividend.
- `src_b`  in  XLEN  multiplier / divisor.
- `stall_req`  out  1  hold EX and earlier stages.
- `busy`  out  1  state ≠ IDLE.
- `res_valid`  out  1  `hi`/`lo` hold a fresh result this cycle.
- `hi`  out  XLEN  high product / remainder.
- `lo`  out  XLEN  low product / quotient.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - With `req_valid & !flush`: latch op and operands.
  - Go to MUL with count = MUL_STAGES−1, or to DIV with count = XLEN−1.
  - DIV/DIVU latch magnitudes (two's-complement abs for DIV) and record the sign of the quotient (sign_a ^ sign_b) and of the remainder (sign_a).
- MUL:
  - Full 2·XLEN product, signed for MULT and unsigned for MULTU.
  - The product may be computed registered or retimed across MUL_STAGES.
  - Decrement count; at 0 load `{hi,lo}` ← product and go to DONE.
- DIV:
  - One restoring step per cycle: remainder shifted left one bit with the next dividend bit brought in, subtract divisor, keep the result if non-negative, shift the quotient bit in.
  - Decrement count; at 0 go to FIX.
- FIX:
  - Negate the quotient if its sign is set; negate the remainder if its sign is set.
  - Load `lo` ← quotient, `hi` ← remainder; go to DONE.
- Divide by zero (`src_b`==0, DIV or DIVU): `lo` = all ones and `hi` = `src_a` as latched, with no sign fixup. Cycle count is unchanged.
- DONE: `res_valid`=1 and go to IDLE unconditionally. `req_valid` is ignored in DONE, because the same instruction is still presented that cycle.
- `flush` in any state: go to IDLE at the next edge; `res_valid` is not raised; `hi`/`lo` keep their previous values. A flush coinciding with DONE still lets that DONE cycle's `res_valid`=1 stand; EX discards it.
- `hi`/`lo` change only on entry to DONE; they hold between operations.
- Widths: product is 2·XLEN; internal remainder is XLEN+1 bits; `src_b` = most-negative with DIV is handled by the abs/negate path (wraps correctly mod 2^XLEN).

## Timing
- Reset (`rst`=0): state IDLE, `hi`=0, `lo`=0, `res_valid`=0, `busy`=0, `stall_req`=0, counters 0. Reset takes effect immediately and overrides any operation in flight.
- `stall_req` = (IDLE & `req_valid` & !`flush`) | MUL | DIV | FIX. It is combinational, so the accept cycle already stalls; DONE does not stall.
- The accept edge is cycle 0.
- Multiply:
  - `stall_req` is high in cycles 0..MUL_STAGES.
  - `res_valid` is in cycle MUL_STAGES+1 (cycle 3 at default).
- Divide:
  - `stall_req` is high in cycles 0..XLEN+1.
  - `res_valid` is in cycle XLEN+2 (cycle 34 at default).
- Back-to-back: a new request is accepted earliest the cycle after DONE, so there is one IDLE cycle between operations.
- Throughput: one operation in flight; no queuing.

## Test plan
- MULT −3 × 5 → at cycle 3, `res_valid`=1, `hi`=FFFFFFFF, `lo`=FFFFFFF1; `stall_req` high cycles 0–2, low cycle 3.
- MULTU FFFFFFFF × FFFFFFFF → `hi`=FFFFFFFE, `lo`=00000001 at cycle 3; repeat with MUL_STAGES=4 → `res_valid` at cycle 5.
- DIV −7 / 2 → at cycle 34, `lo`=FFFFFFFD, `hi`=FFFFFFFF. DIVU 100 / 7 → `lo`=0000000E, `hi`=00000002. DIV 80000000 / FFFFFFFF → `lo`=80000000, `hi`=0.
- DIVU 1234 / 0 → `lo`=FFFFFFFF, `hi`=00001234 at cycle 34.
- DIV started, `flush` at cycle 10 → IDLE at cycle 11, no `res_valid`, `hi`/`lo` unchanged. A new MULT 2×3 at cycle 12 → `lo`=6 at cycle 15.
- `rst` low at cycle 20 of a divide → all outputs 0 immediately. After release, `req_valid` held through DONE → exactly one `res_valid` pulse, with no restart.
